// File: rtl/mwas_pkg.sv
// rtl/mwas_pkg.sv - shared word width, FSM encoding and saturation constants for multiword_addsub_ctrl
package mwas_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Most-significant word of the saturated result; lower words are all-ones / all-zeros.
  localparam logic [WORD_W-1:0] SAT_POS_MSW = 16'h7FFF;
  localparam logic [WORD_W-1:0] SAT_NEG_MSW = 16'h8000;

endpackage

// File: rtl/adder_subtractor_16bit.sv
// rtl/adder_subtractor_16bit.sv - 16-bit adder with carry in/out and signed overflow
// sub_i only inverts B; the +1 of a subtraction comes through cin_i.
module adder_subtractor_16bit
  import mwas_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              sub_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] result_o,
  output logic              cout_o,
  output logic              overflow_o
);

  logic [WORD_W-1:0] b_eff;
  logic [WORD_W-1:0] lo_sum;
  logic [1:0]        hi_sum;

  // Split at the MSB so the carry into bit 15 is visible for overflow.
  always_comb begin
    b_eff      = b_i ^ {WORD_W{sub_i}};
    lo_sum     = {1'b0, a_i[WORD_W-2:0]} + {1'b0, b_eff[WORD_W-2:0]} + {{(WORD_W-1){1'b0}}, cin_i};
    hi_sum     = {1'b0, a_i[WORD_W-1]} + {1'b0, b_eff[WORD_W-1]} + {1'b0, lo_sum[WORD_W-1]};
    result_o   = {hi_sum[0], lo_sum[WORD_W-2:0]};
    cout_o     = hi_sum[1];
    overflow_o = hi_sum[1] ^ lo_sum[WORD_W-1];
  end

endmodule

// File: rtl/multiword_addsub_ctrl.sv
// rtl/multiword_addsub_ctrl.sv - word-serial WORDS x 16-bit add/subtract on one shared 16-bit adder
// Optional MWAS_SAT_EN: saturate the result on signed overflow.
module multiword_addsub_ctrl
  import mwas_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [WORD_W*WORDS-1:0] a_in,
  input  logic [WORD_W*WORDS-1:0] b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W*WORDS-1:0] result,
  output logic                  cout,
  output logic                  overflow
);

  localparam int W  = WORD_W * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sh_q, sh_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d, ovf_q, ovf_d;
  logic            in_ready_q, out_valid_q, out_valid_d;
  logic [W-1:0]    final_val;
  logic [WORD_W-1:0] add_sum;
  logic            add_cout, add_ovf;

  adder_subtractor_16bit u_add16 (
    .a_i        (a_q[WORD_W-1:0]),
    .b_i        (b_q[WORD_W-1:0]),
    .sub_i      (1'b0),
    .cin_i      (carry_q),
    .result_o   (add_sum),
    .cout_o     (add_cout),
    .overflow_o (add_ovf)
  );

`ifdef MWAS_SAT_EN
  logic a_msb_q, a_msb_d;
  logic [W-1:0] sat_val;

  always_comb begin
    sat_val = {W{~a_msb_q}};
    sat_val[W-1 -: WORD_W] = a_msb_q ? SAT_NEG_MSW : SAT_POS_MSW;
    final_val = ovf_q ? sat_val : sh_q;
  end
`else
  assign final_val = sh_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sh_d        = sh_q;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
`ifdef MWAS_SAT_EN
    a_msb_d     = a_msb_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a_in;
          b_d     = op_sub ? ~b_in : b_in;
          carry_d = op_sub;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifdef MWAS_SAT_EN
          a_msb_d = a_in[W-1];
`endif
        end
      end
      ST_RUN: begin
        // Result words enter at the top and shift down, so after WORDS cycles the LSW sits at bit 0.
        sh_d = sh_q >> WORD_W;
        sh_d[W-1 -: WORD_W] = add_sum;
        carry_d = add_cout;
        a_d     = a_q >> WORD_W;
        b_d     = b_q >> WORD_W;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = add_cout;
          ovf_d   = add_ovf;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // First DONE cycle publishes the (possibly saturated) result; valid rises after it.
        if (!out_valid_q) begin
          result_d    = final_val;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sh_q        <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef MWAS_SAT_EN
      a_msb_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sh_q        <= sh_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= out_valid_d;
`ifdef MWAS_SAT_EN
      a_msb_q     <= a_msb_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule
